// File: rtl/execute_md_pkg.sv
// execute_md_pkg: shared types, default widths and op-class helpers for the
// execute-stage multiply/divide back end.
// Build option: define EXECUTE_MD_DIV_EN to include DIV/DIVU support.
package execute_md_pkg;

   localparam int MD_XLEN   = 32;
   localparam int MD_REG_AW = 5;
   localparam int MD_CNT_W  = $clog2(MD_XLEN + 1);

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MFHI  = 3'd5,
      MD_MFLO  = 3'd6
   } md_op_e;

   // Ops that launch an iterative operation (code 7 is never one of these)
   function automatic logic md_is_start(input logic [2:0] op);
`ifdef EXECUTE_MD_DIV_EN
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`else
      return (op == MD_MULT) || (op == MD_MULTU);
`endif
   endfunction

   // Ops that must wait for the unit to be idle
   function automatic logic md_uses_unit(input logic [2:0] op);
      return md_is_start(op) || (op == MD_MFHI) || (op == MD_MFLO);
   endfunction

endpackage

// File: rtl/execute_md_md_unit.sv
// md_unit: radix-2 iterative multiplier (shift-add) and, with
// EXECUTE_MD_DIV_EN, restoring divider. Works on operand magnitudes and
// applies the sign fix on the final step, writing HI/LO at the same edge.
module md_unit
   import execute_md_pkg::*;
#(
   parameter int XLEN = MD_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o,
   output logic            busy_o,
   output logic            div_by_zero_o
);
   localparam int CW = $clog2(XLEN + 1);

   logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic              busy_q, busy_d;
   logic [CW-1:0]     count_q, count_d;
   logic              neg_lo_q, neg_lo_d;

   logic              signed_op, sign_a, sign_b;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] step_acc, prod;
`ifdef EXECUTE_MD_DIV_EN
   logic              is_div_q, is_div_d;
   logic              neg_hi_q, neg_hi_d;
   logic              dbz_q, dbz_d;
   logic [XLEN:0]     div_shift;
   logic [XLEN-1:0]   div_diff;
   logic              div_ge;
`endif

   // Operand magnitudes and sign flags for the signed forms
   always_comb begin
      signed_op = (op_i == MD_MULT) || (op_i == MD_DIV);
      sign_a    = signed_op && a_i[XLEN-1];
      sign_b    = signed_op && b_i[XLEN-1];
      mag_a     = sign_a ? -a_i : a_i;
      mag_b     = sign_b ? -b_i : b_i;
   end

   // One radix-2 step: acc holds {partial HI, multiplier} or {remainder, quotient}
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      step_acc = {mul_sum, acc_q[XLEN-1:1]};
`ifdef EXECUTE_MD_DIV_EN
      div_shift = acc_q[2*XLEN-1:XLEN-1];
      div_ge    = div_shift >= {1'b0, opnd_q};
      div_diff  = div_shift[XLEN-1:0] - opnd_q;
      if (is_div_q) begin
         step_acc = {(div_ge ? div_diff : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
      end
`endif
      prod = neg_lo_q ? -step_acc : step_acc;
   end

   // Start / iterate / complete sequencing and HI/LO update
   always_comb begin
      hi_d     = hi_q;
      lo_d     = lo_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      busy_d   = busy_q;
      count_d  = count_q;
      neg_lo_d = neg_lo_q;
`ifdef EXECUTE_MD_DIV_EN
      is_div_d = is_div_q;
      neg_hi_d = neg_hi_q;
      dbz_d    = 1'b0;
`endif
      if (start_i && !busy_q) begin
         busy_d   = 1'b1;
         count_d  = CW'(XLEN);
         neg_lo_d = sign_a ^ sign_b;
`ifdef EXECUTE_MD_DIV_EN
         is_div_d = (op_i == MD_DIV) || (op_i == MD_DIVU);
         neg_hi_d = sign_a;
         if (is_div_d) begin
            acc_d  = {{XLEN{1'b0}}, mag_a};
            opnd_d = mag_b;
         end else begin
            acc_d  = {{XLEN{1'b0}}, mag_b};
            opnd_d = mag_a;
         end
`else
         acc_d  = {{XLEN{1'b0}}, mag_b};
         opnd_d = mag_a;
`endif
      end else if (busy_q) begin
         acc_d   = step_acc;
         count_d = count_q - CW'(1);
         if (count_q == CW'(1)) begin
            busy_d = 1'b0;
            hi_d   = prod[2*XLEN-1:XLEN];
            lo_d   = prod[XLEN-1:0];
`ifdef EXECUTE_MD_DIV_EN
            if (is_div_q) begin
               // A zero divisor leaves quotient all ones and remainder |a|;
               // restoring the dividend sign then yields HI = op_a exactly.
               lo_d  = (neg_lo_q && (opnd_q != '0)) ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
               hi_d  = neg_hi_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
               dbz_d = (opnd_q == '0);
            end
`endif
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q     <= '0;
         lo_q     <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         busy_q   <= 1'b0;
         count_q  <= '0;
         neg_lo_q <= 1'b0;
`ifdef EXECUTE_MD_DIV_EN
         is_div_q <= 1'b0;
         neg_hi_q <= 1'b0;
         dbz_q    <= 1'b0;
`endif
      end else begin
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         busy_q   <= busy_d;
         count_q  <= count_d;
         neg_lo_q <= neg_lo_d;
`ifdef EXECUTE_MD_DIV_EN
         is_div_q <= is_div_d;
         neg_hi_q <= neg_hi_d;
         dbz_q    <= dbz_d;
`endif
      end
   end

   assign hi_o   = hi_q;
   assign lo_o   = lo_q;
   assign busy_o = busy_q;
`ifdef EXECUTE_MD_DIV_EN
   assign div_by_zero_o = dbz_q;
`else
   assign div_by_zero_o = 1'b0;
`endif

endmodule

// File: rtl/execute_md.sv
// execute_md: EX-stage back end. Stalls MD-class ops while the unit is busy,
// launches MULT/MULTU (and DIV/DIVU with EXECUTE_MD_DIV_EN), selects
// HI/LO for MFHI/MFLO and registers the EX/MEM stage.
module execute_md
   import execute_md_pkg::*;
#(
   parameter int XLEN   = MD_XLEN,
   parameter int REG_AW = MD_REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [2:0]        md_op,
   input  logic [XLEN-1:0]   op_a,
   input  logic [XLEN-1:0]   op_b,
   input  logic [XLEN-1:0]   alu_res,
   input  logic [REG_AW-1:0] rd,
   input  logic              reg_write,
   input  logic              flush,
   output logic              stall_ex,
   output logic              md_busy,
   output logic              out_valid,
   output logic [XLEN-1:0]   out_res,
   output logic [REG_AW-1:0] out_rd,
   output logic              out_reg_write,
   output logic              div_by_zero
);
   logic              is_md, is_start, accept;
   logic [XLEN-1:0]   hi, lo;
   logic              out_valid_q, out_valid_d;
   logic [XLEN-1:0]   out_res_q, out_res_d;
   logic [REG_AW-1:0] out_rd_q, out_rd_d;
   logic              out_reg_write_q, out_reg_write_d;

   // Stall only MD-class ops while busy; a flush kills the stall as well
   always_comb begin
      is_md    = md_uses_unit(md_op);
      is_start = md_is_start(md_op);
      stall_ex = in_valid && !flush && is_md && md_busy;
      accept   = in_valid && !flush && !stall_ex;
   end

   md_unit #(.XLEN(XLEN)) u_md (
      .clk          (clk),
      .rst          (rst),
      .start_i      (accept && is_start),
      .op_i         (md_op),
      .a_i          (op_a),
      .b_i          (op_b),
      .hi_o         (hi),
      .lo_o         (lo),
      .busy_o       (md_busy),
      .div_by_zero_o(div_by_zero)
   );

   // EX/MEM next state: accepted instruction or a bubble
   always_comb begin
      out_valid_d     = 1'b0;
      out_reg_write_d = 1'b0;
      out_res_d       = out_res_q;
      out_rd_d        = out_rd_q;
      if (accept) begin
         out_valid_d     = 1'b1;
         out_rd_d        = rd;
         out_reg_write_d = reg_write && !is_start;
         if (md_op == MD_MFHI) begin
            out_res_d = hi;
         end else if (md_op == MD_MFLO) begin
            out_res_d = lo;
         end else begin
            out_res_d = alu_res;
         end
      end
   end

   // EX/MEM pipeline register
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q     <= 1'b0;
         out_res_q       <= '0;
         out_rd_q        <= '0;
         out_reg_write_q <= 1'b0;
      end else begin
         out_valid_q     <= out_valid_d;
         out_res_q       <= out_res_d;
         out_rd_q        <= out_rd_d;
         out_reg_write_q <= out_reg_write_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign out_res       = out_res_q;
   assign out_rd        = out_rd_q;
   assign out_reg_write = out_reg_write_q;

endmodule

// File: tb/tb_execute_md.sv
// tb_execute_md: table-driven MD vectors, hand-written stall/flush/reset
// sequences, and a randomized cycle-by-cycle run against an arithmetic model.
// Honours EXECUTE_MD_DIV_EN the same way as the design.
module tb_execute_md;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [2:0]  md_op = 3'd0;
   logic [31:0] op_a = '0, op_b = '0, alu_res = '0;
   logic [4:0]  rd = '0;
   logic        reg_write = 1'b0;
   logic        flush = 1'b0;
   logic        stall_ex, md_busy, out_valid, out_reg_write, div_by_zero;
   logic [31:0] out_res;
   logic [4:0]  out_rd;

   int          passed = 0;
   int          total  = 0;
   logic        st;
   logic [31:0] m_hi = '0, m_lo = '0;

   always #5 clk = ~clk;

   execute_md dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .md_op(md_op),
      .op_a(op_a), .op_b(op_b), .alu_res(alu_res), .rd(rd),
      .reg_write(reg_write), .flush(flush), .stall_ex(stall_ex),
      .md_busy(md_busy), .out_valid(out_valid), .out_res(out_res),
      .out_rd(out_rd), .out_reg_write(out_reg_write), .div_by_zero(div_by_zero)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b, hi, lo;
      logic        dbz;
   } vec_t;
   vec_t tbl [10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic logic tb_start(input logic [2:0] op);
`ifdef EXECUTE_MD_DIV_EN
      return (op >= 3'd1) && (op <= 3'd4);
`else
      return (op == 3'd1) || (op == 3'd2);
`endif
   endfunction

   function automatic logic tb_md(input logic [2:0] op);
      return tb_start(op) || (op == 3'd5) || (op == 3'd6);
   endfunction

   // {dbz, HI, LO} from plain 64-bit arithmetic
   function automatic logic [64:0] md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] p, ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (op)
         3'd1: begin p = 64'(sa * sb); return {1'b0, p}; end
         3'd2: begin p = ua * ub; return {1'b0, p}; end
         3'd3, 3'd4: begin
            if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
            if (op == 3'd3) begin
               q = sa / sb;
               r = sa % sb;
               p = {64'(r) << 32} | (64'(q) & 64'hFFFF_FFFF);
            end else begin
               p = ((ua % ub) << 32) | (ua / ub);
            end
            return {1'b0, p};
         end
         default: return '0;
      endcase
   endfunction

   // Drive one cycle's inputs, sample stall before the edge, outputs after it
   task automatic cyc(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] alu, input logic [4:0] r, input logic rw, input logic fl,
                      output logic s);
      in_valid = v; md_op = op; op_a = a; op_b = b; alu_res = alu;
      rd = r; reg_write = rw; flush = fl;
      #1;
      s = stall_ex;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      logic s;
      cyc(1'b0, 3'd0, '0, '0, '0, '0, 1'b0, 1'b0, s);
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 40 && md_busy; i++) idle();
      chk(name, 64'(md_busy), 64'd0);
   endtask

   task automatic read_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
      logic s;
      cyc(1'b1, 3'd5, '0, '0, 32'hDEAD_BEEF, 5'd9, 1'b1, 1'b0, s);
      chk({name, "_hi"}, {out_valid, out_reg_write, out_rd, out_res}, {1'b1, 1'b1, 5'd9, eh});
      cyc(1'b1, 3'd6, '0, '0, 32'hDEAD_BEEF, 5'd10, 1'b1, 1'b0, s);
      chk({name, "_lo"}, {out_valid, out_reg_write, out_rd, out_res}, {1'b1, 1'b1, 5'd10, el});
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      logic        s, start;
      int          nbusy, ndbz;
      logic [31:0] eh, el;
      logic        edbz;
      start = tb_start(v.op);
      eh = start ? v.hi : m_hi;
      el = start ? v.lo : m_lo;
      edbz = start && v.dbz;
      cyc(1'b1, v.op, v.a, v.b, 32'h0BAD_F00D, 5'd3, 1'b1, 1'b0, s);
      chk("vec_start_stall", 64'(s), 64'd0);
      chk("vec_start_ex", {out_valid, out_reg_write, out_res}, {1'b1, !start, 32'h0BAD_F00D});
      nbusy = 0;
      ndbz = 0;
      while (md_busy && nbusy < 40) begin
         nbusy++;
         idle();
         ndbz += int'(div_by_zero);
      end
      idle();
      ndbz += int'(div_by_zero);
      chk("vec_busy_cycles", 64'(nbusy), start ? 64'd32 : 64'd0);
      chk("vec_dbz_pulses", 64'(ndbz), 64'(edbz));
      read_hilo("vec", eh, el);
      m_hi = eh;
      m_lo = el;
      $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h busy=%0d", idx, v.op, v.a, v.b, eh, el, nbusy);
   endtask

   initial begin
      logic [64:0] r;
      int          n;

      tbl[0] = '{3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
      tbl[1] = '{3'd2, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0};
      tbl[2] = '{3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      tbl[3] = '{3'd4, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0};
      tbl[4] = '{3'd3, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
      tbl[5] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
      tbl[6] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
      tbl[7] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      tbl[8] = '{3'd3, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
      tbl[9] = '{3'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("reset_state", {out_valid, out_reg_write, out_rd, out_res, md_busy, div_by_zero, stall_ex},
          '0);
      $display("reset done");

      // Plain ALU pass-through and flush-beats-accept
      cyc(1'b1, 3'd0, '0, '0, 32'h1357_9BDF, 5'd17, 1'b1, 1'b0, st);
      chk("alu_pass", {out_valid, out_reg_write, out_rd, out_res}, {1'b1, 1'b1, 5'd17, 32'h1357_9BDF});
      cyc(1'b1, 3'd7, '0, '0, 32'h2468_ACE0, 5'd4, 1'b1, 1'b0, st);
      chk("reserved_op", {out_valid, out_reg_write, out_rd, out_res, md_busy}, {1'b1, 1'b1, 5'd4, 32'h2468_ACE0, 1'b0});
      cyc(1'b1, 3'd1, 32'd5, 32'd6, 32'h1111_2222, 5'd5, 1'b1, 1'b1, st);
      chk("flush_kills", {out_valid, out_reg_write, md_busy}, 3'b000);
      $display("alu/flush sequence done");

      // Table vectors
      for (int i = 0; i < 10; i++) run_vec(i, tbl[i]);

      // MULT immediately followed by MFLO rd=8
      r = md_ref(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
      cyc(1'b1, 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, '0, 5'd2, 1'b1, 1'b0, st);
      n = 0;
      cyc(1'b1, 3'd6, '0, '0, 32'h5555_5555, 5'd8, 1'b1, 1'b0, st);
      while (st && n < 40) begin
         n++;
         cyc(1'b1, 3'd6, '0, '0, 32'h5555_5555, 5'd8, 1'b1, 1'b0, st);
      end
      chk("mflo_stall_cycles", 64'(n), 64'd32);
      chk("mflo_after_stall", {out_valid, out_reg_write, out_rd, out_res}, {1'b1, 1'b1, 5'd8, r[31:0]});
      m_hi = r[63:32];
      m_lo = r[31:0];
      $display("mult+mflo: stalled %0d cycles, lo=%h", n, out_res);

      // MFHI held stalled, then flushed; the MULT still completes
      r = md_ref(3'd1, 32'd5, 32'hFFFF_FFFD);
      cyc(1'b1, 3'd1, 32'd5, 32'hFFFF_FFFD, '0, 5'd2, 1'b1, 1'b0, st);
      n = 0;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 3'd5, '0, '0, '0, 5'd12, 1'b1, 1'b0, st);
         n += int'(st);
      end
      chk("mfhi_held_stall", {64'(n), 1'b0, out_valid, out_reg_write}, {64'd3, 3'b000});
      cyc(1'b1, 3'd5, '0, '0, '0, 5'd12, 1'b1, 1'b1, st);
      chk("flush_drops_stall", {st, out_valid, out_reg_write, md_busy}, 4'b0001);
      wait_done("flush_mult_done");
      read_hilo("flush_mult", r[63:32], r[31:0]);
      m_hi = r[63:32];
      m_lo = r[31:0];
      $display("mfhi flush: hi=%h lo=%h", r[63:32], r[31:0]);

      // Back-to-back MULT then MULTU: second accepted as busy falls
      cyc(1'b1, 3'd1, 32'h0000_0777, 32'h0000_0123, '0, 5'd2, 1'b1, 1'b0, st);
      r = md_ref(3'd2, 32'hCAFE_BABE, 32'h0000_1001);
      n = 0;
      cyc(1'b1, 3'd2, 32'hCAFE_BABE, 32'h0000_1001, '0, 5'd2, 1'b1, 1'b0, st);
      while (st && n < 40) begin
         n++;
         cyc(1'b1, 3'd2, 32'hCAFE_BABE, 32'h0000_1001, '0, 5'd2, 1'b1, 1'b0, st);
      end
      chk("b2b_stall_cycles", 64'(n), 64'd32);
      chk("b2b_second_start", {out_valid, out_reg_write, md_busy}, 3'b101);
      wait_done("b2b_done");
      read_hilo("b2b", r[63:32], r[31:0]);
      $display("back-to-back: stalled %0d, hi=%h lo=%h", n, r[63:32], r[31:0]);

      // Reset at count=10 of a MULT
      cyc(1'b1, 3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h9999_9999, 5'd21, 1'b1, 1'b0, st);
      repeat (22) idle();
      chk("pre_reset_busy", 64'(md_busy), 64'd1);
      rst = 1'b1;
      idle();
      rst = 1'b0;
      #1;
      chk("mid_reset_state", {out_valid, out_reg_write, out_rd, out_res, md_busy, div_by_zero, stall_ex}, '0);
      m_hi = '0;
      m_lo = '0;
      read_hilo("mid_reset", 32'd0, 32'd0);
      $display("mid-op reset done");

      // Randomized cycles against the arithmetic model
      begin
         int          md_left;
         logic [31:0] p_hi, p_lo;
         logic        p_dbz, exp_dbz, v, fl, rw, acc, exp_st, start;
         logic [2:0]  op;
         logic [31:0] a, b, alu, exp_res;
         logic [4:0]  rr;
         md_left = 0;
         p_hi = '0; p_lo = '0; p_dbz = 1'b0;
         for (int c = 0; c < 400; c++) begin
            v   = ($urandom_range(0, 9) < 7);
            op  = 3'($urandom_range(0, 7));
            fl  = ($urandom_range(0, 9) == 0);
            a   = $urandom;
            b   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 20)) - 32'd10;
            alu = $urandom;
            rr  = 5'($urandom_range(0, 31));
            rw  = 1'($urandom_range(0, 1));
            start   = tb_start(op);
            exp_st  = v && !fl && tb_md(op) && (md_left > 0);
            acc     = v && !fl && !exp_st;
            exp_res = (op == 3'd5) ? m_hi : (op == 3'd6) ? m_lo : alu;
            cyc(v, op, a, b, alu, rr, rw, fl, st);
            chk("rnd_stall", 64'(st), 64'(exp_st));
            exp_dbz = 1'b0;
            if (md_left > 0) begin
               md_left--;
               if (md_left == 0) begin
                  m_hi = p_hi;
                  m_lo = p_lo;
                  exp_dbz = p_dbz;
               end
            end
            if (acc && start) begin
               r = md_ref(op, a, b);
               p_dbz = r[64];
               p_hi = r[63:32];
               p_lo = r[31:0];
               md_left = 32;
            end
            chk("rnd_valid_rw", {out_valid, out_reg_write}, {acc, acc && rw && !start});
            if (acc) chk("rnd_res_rd", {out_rd, out_res}, {rr, exp_res});
            chk("rnd_busy_dbz", {md_busy, div_by_zero}, {(md_left > 0), exp_dbz});
            if (acc) $display("rnd %0d op=%0d a=%h b=%h res=%h busy=%0d", c, op, a, b, out_res, md_busy);
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Hard time limit in case the flow itself wedges
   initial begin
      #2000000;
      $display("FAIL timeout: simulation time limit reached, passed=%0d total=%0d", passed, total);
      $fatal(1);
   end

endmodule

// File: doc/execute_md.md
# execute_md

Parametrised execute-stage back end for the MIPS R2000 pipeline. It adds an iterative multiply/divide unit with HI/LO registers (MULT, MULTU, DIV, DIVU, MFHI, MFLO) and stall/flush handling to the EX→MEM pipeline register. It sits between the ALU/forwarding logic of EX and the MEM stage. It consumes already-forwarded operands and the ALU result, and drives the EX/MEM register plus a stall back to ID/EX.

## Interface
Parameters:
- XLEN, 32, datapath width; operands, ALU result, HI and LO are XLEN bits
- REG_AW, 5, register-index width

Ports (name, direction, width, meaning):
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  an instruction occupies EX this cycle
- md_op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 reserved (treated as NONE)
- op_a  in  XLEN  forwarded rs operand (multiplicand / dividend)
- op_b  in  XLEN  forwarded rt operand (multiplier / divisor)
- alu_res  in  XLEN  ALU result, used when md_op is not MFHI/MFLO
- rd  in  REG_AW  destination register
- reg_write  in  1  destination write enable
- flush  in  1  kill the instruction currently in EX
- stall_ex  out  1  combinational; hold IF/ID/EX this cycle
- md_busy  out  1  multiply/divide iteration in progress
- out_valid  out  1  EX/MEM valid
- out_res  out  XLEN  EX/MEM result
- out_rd  out  REG_AW  EX/MEM destination
- out_reg_write  out  1  EX/MEM write enable
- div_by_zero  out  1  one-cycle pulse when a DIV/DIVU with divisor 0 completes

## Operation
- Acceptance:
  - The instruction is accepted when in_valid && !flush && !stall_ex.
  - stall_ex = in_valid && !flush && md_op∈{1..6} && md_busy.
  - Non-MD instructions never stall.
- Start:
  - Accepting MULT/MULTU/DIV/DIVU captures op_a and op_b, sets md_busy, and loads count = XLEN.
  - The instruction itself passes to EX/MEM with out_reg_write forced to 0.
- Iteration: one radix-2 step per cycle.
  - Multiply: shift-add on operand magnitudes.
  - Divide: restoring division on operand magnitudes.
- Sign rules:
  - Signed product is negated when op_a[XLEN-1] ^ op_b[XLEN-1].
  - Signed quotient follows the same rule.
  - Signed remainder takes the sign of the dividend.
- Results:
  - Multiply: HI = upper XLEN bits, LO = lower XLEN bits of the 2·XLEN product.
  - Divide: LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = op_a, div_by_zero pulses on the completion edge.
- MFHI/MFLO: out_res = HI or LO. Otherwise out_res = alu_res.
- Flush:
  - EX/MEM loads out_valid = 0 and out_reg_write = 0.
  - No MD start occurs for the flushed instruction.
  - An already-running MD operation continues to completion.
- Not accepted but not flushed: when stall_ex is high, EX/MEM loads a bubble (out_valid = 0, out_reg_write = 0).

## Timing
- Reset: on the rst edge, out_valid, out_res, out_rd, out_reg_write, HI, LO, md_busy, count and div_by_zero all become 0. stall_ex is therefore 0.
- Reset mid-operation aborts the operation and clears HI/LO.
- EX/MEM latency: 1 cycle from acceptance.
- MD latency:
  - Operands are captured at edge E0.
  - HI/LO are written and md_busy is cleared at edge E_XLEN.
  - The sign fix is folded into the final step.
- An MFLO issued in the cycle after E0 stalls for XLEN cycles. It is accepted in the cycle following E_XLEN and sees the new LO.
- An MD op issued in the same cycle md_busy falls is accepted with no stall.
- A back-to-back MULT after MULT stalls until the first completes; there is no queueing.
- rst has priority over flush, and flush has priority over acceptance.

## Configuration
- EXECUTE_MD_DIV_EN defined: DIV/DIVU are implemented as above and div_by_zero is live.
- EXECUTE_MD_DIV_EN undefined:
  - DIV/DIVU are treated as NONE: no busy, HI/LO unchanged.
  - div_by_zero is tied 0.
  - The divider datapath is removed.

## Structure
- execute_md_pkg holds:
  - md_op_e enum (NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO)
  - default XLEN and REG_AW localparams
  - count width $clog2(XLEN+1)
- Sub-module md_unit (iterative multiplier/divider, HI/LO, busy, count, div_by_zero).
- execute_md holds the stall/flush logic and the EX/MEM register.

## Test plan
- Reset, then MULT with op_a=0xFFFFFFFE and op_b=3 -> after XLEN cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV with op_a=0xFFFFFFF9 (-7) and op_b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with 7 and 2 -> LO=3, HI=1.
- MULT followed immediately by MFLO with rd=8 -> stall_ex high for exactly 32 cycles, then out_res=LO, out_rd=8, out_reg_write=1.
- DIV with op_b=0 and op_a=0x1234 -> LO=0xFFFFFFFF, HI=0x1234, div_by_zero high for one cycle. With EXECUTE_MD_DIV_EN undefined -> HI/LO unchanged and md_busy stays 0.
- MFHI held stalled, then flush asserted -> stall_ex drops the same cycle and out_valid=0 next cycle; the running MULT still completes.
- rst asserted at count=10 of a MULT -> next cycle md_busy=0, HI=LO=0, and all EX/MEM outputs are 0.
